cb_dinb_seq: RTL
================

CB_DINB_SEQ -- requirements
Module: cb_dinb_seq

Interface
REQ-001 SHALL have parameter SEQ_CNT_DW, default 5: width of the beat counter and command length.
REQ-002 SHALL have parameter CB_DINB_SEL_DW, default 5: width of the select word, laid out as {type[CB_DINB_SEL_DW-1:2], dir[1:0]}.
REQ-003 SHALL have parameter ADDR_W, default 8: width of the C-buffer read address.
REQ-004 SHALL have parameter RD_LAT, default 2, legal range 1..4: C-buffer read latency in cycles.
REQ-005 SHALL have port clk, input, 1: the single clock; all flops on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-008 SHALL have port cmd_ready, output, 1: the block can accept a command.
REQ-009 SHALL have port cmd_dir, input, 2: direction code (00 IDLE, 01 POS, 10 NEG, 11 NEW).
REQ-010 SHALL have port cmd_lk0, input, 1: landmark half-select for NEW.
REQ-011 SHALL have port cmd_base, input, ADDR_W: first C-buffer row.
REQ-012 SHALL have port cmd_len, input, SEQ_CNT_DW: number of rows to stream.
REQ-013 SHALL have port C_rd_en, output, 1: C-buffer read strobe.
REQ-014 SHALL have port C_rd_addr, output, ADDR_W: C-buffer read address.
REQ-015 SHALL have port CB_dinb_sel, output, CB_DINB_SEL_DW: select word to the CB port-B data mapper.
REQ-016 SHALL have port l_k_0, output, 1: landmark half-select to the mapper.
REQ-017 SHALL have port seq_cnt_out, output, SEQ_CNT_DW: 1-based beat index; 0 when no beat is active.
REQ-018 SHALL have ports busy (output, 1: high from acceptance to done) and done (output, 1: one-cycle completion pulse).

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-020 SHALL drive cmd_ready=1 only in IDLE; acceptance is cmd_valid&cmd_ready at cycle T.
REQ-021 SHALL, on acceptance, latch cmd_dir, cmd_lk0, cmd_base and cmd_len; l_k_0 SHALL equal the latched cmd_lk0 from T+1 until the next acceptance.
REQ-022 SHALL, on acceptance with cmd_len=N>0, go to ISSUE and drive C_rd_en=1 with C_rd_addr=(cmd_base+i) mod 2^ADDR_W at cycle T+1+i, for i=0..N-1.
REQ-023 SHALL drive C_rd_en=0 and hold C_rd_addr at its last value in all other cycles.
REQ-024 SHALL carry each issued read through an RD_LAT-deep valid/index pipeline.
REQ-025 SHALL drive CB_dinb_sel={3'b001,latched dir} and seq_cnt_out=i+1 at cycle T+1+i+RD_LAT.
REQ-026 SHALL drive CB_dinb_sel=0 and seq_cnt_out=0 whenever no beat is active.
REQ-027 SHALL move ISSUE->DRAIN after the Nth read, DRAIN->DONE when the pipeline is empty, and DONE->IDLE after one cycle.
REQ-028 SHALL pulse done=1 only in DONE, at cycle T+N+RD_LAT+1.
REQ-029 SHALL hold busy=1 from T+1 through the done cycle inclusive.
REQ-030 SHALL, for cmd_len=0, go directly to DONE: no reads, no beats, done at T+1.
REQ-031 SHALL, for cmd_dir=00, run the full sequence with CB_dinb_sel lower bits 00.
REQ-032 SHALL ignore cmd_valid while cmd_ready=0; no queuing.
REQ-033 SHALL emit beats back-to-back with no bubbles.
REQ-034 SHALL allow the next command to be accepted in the cycle after done, giving a gap of RD_LAT+2 cycles between the last beat of one command and the first beat of the next.

Reset
REQ-035 SHALL, while sys_rst_n=0, force FSM=IDLE, the pipeline cleared, cmd_ready=0, C_rd_en=0, C_rd_addr=0, CB_dinb_sel=0, l_k_0=0, seq_cnt_out=0, busy=0 and done=0.
REQ-036 SHALL raise cmd_ready=1 on the first clock edge after deassertion.
REQ-037 SHALL, on reset mid-sequence, discard all in-flight beats and SHALL NOT emit done for the aborted command.

Verification
REQ-038 SHALL be verified with: POS, base=0x10, len=4, RD_LAT=2, accept at T -> addr 0x10..0x13 at T+1..T+4, sel=5'b00101 with seq 1..4 at T+3..T+6, done at T+7.
REQ-039 SHALL be verified with: NEW, lk0=1, len=2 -> sel=5'b00111, l_k_0=1, seq 1,2; repeat with lk0=0 -> l_k_0=0.
REQ-040 SHALL be verified with: base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-041 SHALL be verified with: len=0 -> no C_rd_en, no sel activity, done at T+1, cmd_ready back at T+2.
REQ-042 SHALL be verified with: cmd_valid held high during a NEG len=3 run -> exactly one acceptance per done; second command's first read at done+2.
REQ-043 SHALL be verified with: sys_rst_n pulsed low at beat 2 of len=8 -> all outputs 0 immediately, no done, clean acceptance after release.

Source files
------------

// File: rtl/cb_dinb_seq.sv
// -----------------------------------------------------------------------------
// cb_dinb_seq
//   Streams a burst of C-buffer reads and, RD_LAT cycles later, presents one
//   beat per read to the CB port-B data mapper (select word + 1-based index).
//
//   Ports
//     clk, sys_rst_n        clock (rising edge), async active-low reset
//     cmd_valid/cmd_ready   command handshake; ready only while idle
//     cmd_dir, cmd_lk0      direction code and landmark half-select
//     cmd_base, cmd_len     first row and number of rows to stream
//     C_rd_en, C_rd_addr    C-buffer read strobe / address
//     CB_dinb_sel, l_k_0    mapper select word {type, dir} and half-select
//     seq_cnt_out           1-based beat index, 0 when no beat is active
//     busy, done            busy from acceptance to done; done is a 1-cycle pulse
//
//   State   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a command, cmd_ready high
//   S_ISSUE | one C-buffer read per cycle, cmd_len reads in total
//   S_DRAIN | reads finished, waiting for the read pipeline to empty
//   S_DONE  | one-cycle done pulse, returns to idle
//
//   RD_LAT must be 1..4.
// -----------------------------------------------------------------------------
module cb_dinb_seq #(
  parameter int SEQ_CNT_DW     = 5,
  parameter int CB_DINB_SEL_DW = 5,
  parameter int ADDR_W         = 8,
  parameter int RD_LAT         = 2
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_dir,
  input  logic                      cmd_lk0,
  input  logic [ADDR_W-1:0]         cmd_base,
  input  logic [SEQ_CNT_DW-1:0]     cmd_len,
  output logic                      C_rd_en,
  output logic [ADDR_W-1:0]         C_rd_addr,
  output logic [CB_DINB_SEL_DW-1:0] CB_dinb_sel,
  output logic                      l_k_0,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic                      busy,
  output logic                      done
);

  localparam int TYPE_W = CB_DINB_SEL_DW - 2;
  localparam logic [TYPE_W-1:0] SEL_TYPE = TYPE_W'(1);
  // Every pipeline stage except the output stage.
  localparam logic [RD_LAT-1:0] UPSTREAM_M = ~(RD_LAT'(1) << (RD_LAT - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    rd_en_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [SEQ_CNT_DW-1:0]   cnt_q;
  logic [SEQ_CNT_DW-1:0]   len_q;
  logic [1:0]              dir_q;
  logic                    lk0_q;

  logic [RD_LAT-1:0]       vld_q;
  logic [SEQ_CNT_DW-1:0]   idx_q [RD_LAT];

  logic [ADDR_W-1:0]       addr_d;
  logic [SEQ_CNT_DW-1:0]   cnt_d;
  logic                    beat_vld;

  assign addr_d = addr_q + ADDR_W'(1);
  assign cnt_d  = cnt_q + SEQ_CNT_DW'(1);

  // cnt_q holds the 1-based index of the read currently on C_rd_en.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= 2'b00;
      lk0_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            dir_q   <= cmd_dir;
            lk0_q   <= cmd_lk0;
            len_q   <= cmd_len;
            if (cmd_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              rd_en_q <= 1'b1;
              addr_q  <= cmd_base;
              cnt_q   <= SEQ_CNT_DW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (cnt_q == len_q) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
          end
        end
        S_DRAIN: begin
          // Leave when only the output stage may still hold a beat, so the
          // done pulse lands in the cycle right after the last beat.
          if ((vld_q & UPSTREAM_M) == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Read-latency pipeline: tracks which cycles carry returning data and
  // the beat index that belongs to it.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        idx_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en_q;
      idx_q[0] <= cnt_q;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  // dir_q is stable across a whole burst: a new command is only accepted
  // after the pipeline has drained.
  assign beat_vld    = vld_q[RD_LAT-1];
  assign CB_dinb_sel = beat_vld ? {SEL_TYPE, dir_q} : '0;
  assign seq_cnt_out = beat_vld ? idx_q[RD_LAT-1] : '0;

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign C_rd_en   = rd_en_q;
  assign C_rd_addr = addr_q;
  assign l_k_0     = lk0_q;

endmodule
